nor32_reg: RTL and testbench
============================

// Module: nor32_reg
// PURPOSE
//  Registered bitwise NOR unit for the MiniMIPS ALU datapath (NOR instruction).
//  Computes R = ~(A | B) per bit over a WIDTH-bit word, with a 1-cycle registered output.
//  Sits between the operand-select muxes and the ALU result mux.
// PARAMETERS
//  WIDTH  32  operand/result width in bits; legal range 1..64
// PORTS
//  clk        in   1      single clock; all state updates on rising edge
//  reset      in   1      synchronous, active-high reset
//  in_valid   in   1      A/B hold a valid operand pair this cycle
//  A          in   WIDTH  operand 1
//  B          in   WIDTH  operand 2
//  out_valid  out  1      R holds a new result this cycle
//  R          out  WIDTH  registered result ~(A | B)
//  zero       out  1      present only with NOR32_ZERO_FLAG_EN; registered (R == 0)
// BEHAVIOUR
//  - Reset, sampled on a rising clk edge with reset=1: R=0, out_valid=0, zero=1 (if built).
//  - Reset has priority over in_valid in the same cycle; the operand pair is dropped.
//  - Latency exactly 1 cycle: in_valid=1 at edge N -> R=~(A|B), out_valid=1 after edge N.
//  - in_valid=0 at an edge: out_valid=0 after the edge, R and zero hold their previous values.
//  - Back-to-back in_valid accepted every cycle; no backpressure, no stall input.
//  - Purely bitwise: bit i of R depends only on bit i of A and B; no carry or sign logic.
//  - Boundaries: A or B all-ones -> R=0; A=B=0 -> R all-ones; A=~B -> R=0.
//  - X on A/B while in_valid=0 must not propagate into R.
// CONFIGURATION
//  - Macro NOR32_ZERO_FLAG_EN defined: port zero exists, updated on the same edge as R
//    as (~(A|B) == 0); held when in_valid=0; reset value 1.
//  - Macro undefined: port zero and its register are absent; all other behaviour identical.
// STRUCTURE
//  - Package nor32_pkg: localparam NOR32_WIDTH=32; typedef logic [NOR32_WIDTH-1:0] nor32_word_t.
//  - One combinational sub-module nor32_core (A, B -> Y=~(A|B), width WIDTH).
//  - Top nor32_reg instantiates nor32_core and holds the R/out_valid/zero registers.
// TESTING
//  1. reset=1 for 2 edges -> R=0, out_valid=0 (zero=1 if built).
//  2. A=32'hFFFFFFFF, B=32'h40A00400, in_valid=1 -> next cycle R=32'h00000000, out_valid=1.
//  3. A=32'h22220225, B=32'hC2420423, in_valid=1 -> next cycle R=32'h1D9DF9D8, out_valid=1.
//  4. A=0, B=0 then in_valid=0 with A=B=32'hFFFFFFFF -> R=32'hFFFFFFFF, then held, out_valid 1 then 0.
//  5. Back-to-back pairs from tests 2 and 3 on consecutive cycles -> R=0 then 32'h1D9DF9D8.
//  6. reset=1 with in_valid=1 in the same cycle -> R=0, out_valid=0; zero tracks R==0 when built.

Source files
------------

// File: rtl/nor32_pkg.sv
// Shared constants and types for the registered NOR unit.
package nor32_pkg;

  localparam int NOR32_WIDTH = 32;

  typedef logic [NOR32_WIDTH-1:0] nor32_word_t;

endpackage

// File: rtl/nor32_if.sv
// Operand/result bundle for the NOR unit.
// Optional feature macro: NOR32_ZERO_FLAG_EN adds the registered zero flag.
// Handshake: in_valid qualifies A/B for one cycle; out_valid marks a fresh R
// exactly one cycle later. There is no ready; every valid pair is accepted.
interface nor32_if
  import nor32_pkg::*;
#(
  parameter int WIDTH = NOR32_WIDTH
);

  logic             in_valid;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             out_valid;
  logic [WIDTH-1:0] R;
`ifdef NOR32_ZERO_FLAG_EN
  logic             zero;
`endif

`ifdef NOR32_ZERO_FLAG_EN
  modport master (output in_valid, output A, output B,
                  input out_valid, input R, input zero);
  modport slave  (input in_valid, input A, input B,
                  output out_valid, output R, output zero);
`else
  modport master (output in_valid, output A, output B,
                  input out_valid, input R);
  modport slave  (input in_valid, input A, input B,
                  output out_valid, output R);
`endif

endinterface

// File: rtl/nor32_core.sv
// Combinational bitwise NOR: each result bit depends only on the same bit of A and B.
module nor32_core #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Y
);

  assign Y = ~(A | B);

endmodule

// File: rtl/nor32_reg.sv
// Registered NOR unit for the ALU datapath: R = ~(A | B) with one cycle of latency.
// Optional feature macro: NOR32_ZERO_FLAG_EN adds a registered (R == 0) flag.
module nor32_reg
  import nor32_pkg::*;
#(
  parameter int WIDTH = NOR32_WIDTH
) (
  input logic    clk,
  input logic    reset,
  nor32_if.slave bus
);

  logic [WIDTH-1:0] nor_y;
  logic [WIDTH-1:0] r_q;
  logic             valid_q;

  nor32_core #(.WIDTH(WIDTH)) u_core (
    .A (bus.A),
    .B (bus.B),
    .Y (nor_y)
  );

  // Result register: loads only on valid operands, so junk on idle cycles never reaches R.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        r_q <= nor_y;
      end
    end
  end

  assign bus.R         = r_q;
  assign bus.out_valid = valid_q;

`ifdef NOR32_ZERO_FLAG_EN
  logic zero_q;

  // Zero flag follows the same load/hold rule as R; a reset R of 0 means zero=1.
  always_ff @(posedge clk) begin
    if (reset) begin
      zero_q <= 1'b1;
    end else if (bus.in_valid) begin
      zero_q <= (nor_y == '0);
    end
  end

  assign bus.zero = zero_q;
`endif

endmodule

// File: tb/tb_nor32_reg.sv
// Self-checking bench for nor32_reg: directed boundary cases plus random traffic
// against a behavioural model of the registered NOR.
module tb_nor32_reg;
  import nor32_pkg::*;

  logic clk;
  logic reset;

  nor32_if #(.WIDTH(NOR32_WIDTH)) bus ();

  nor32_reg #(.WIDTH(NOR32_WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model state: what the outputs must be after the last edge.
  nor32_word_t m_r;
  logic        m_valid;
  logic        m_zero;
  logic        model_ready = 1'b0;

  // Scoreboard of results still owed by the DUT.
  logic [NOR32_WIDTH-1:0] exp_q[$];

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // One clock of stimulus: drive inputs, let the edge happen, advance the model.
  task automatic cycle(input logic rst, input logic v, input nor32_word_t a, input nor32_word_t b);
    reset        = rst;
    bus.in_valid = v;
    bus.A        = a;
    bus.B        = b;
    @(posedge clk);
    if (rst) begin
      m_r     = '0;
      m_valid = 1'b0;
      m_zero  = 1'b1;
      exp_q.delete();
    end else if (v) begin
      m_r     = ~(a | b);
      m_valid = 1'b1;
      m_zero  = (m_r == 0);
      exp_q.push_back(~(a | b));
    end else begin
      m_valid = 1'b0;
    end
    model_ready = 1'b1;
    #1;
  endtask

  task automatic check_out(input string name, input logic v_exp, input nor32_word_t r_exp);
    @(negedge clk);
    check({name, ".out_valid"}, 64'(bus.out_valid), 64'(v_exp));
    check({name, ".R"}, 64'(bus.R), 64'(r_exp));
  endtask

  // Compare process: every cycle, outputs vs model, and results vs scoreboard.
  always @(negedge clk) begin
    if (model_ready) begin
      check("model.out_valid", 64'(bus.out_valid), 64'(m_valid));
      check("model.R", 64'(bus.R), 64'(m_r));
`ifdef NOR32_ZERO_FLAG_EN
      check("model.zero", 64'(bus.zero), 64'(m_zero));
`endif
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          check("sb.unexpected_result", 64'(bus.out_valid), 64'(1'b0));
        end else begin
          check("sb.R", 64'(bus.R), 64'(exp_q.pop_front()));
        end
      end
    end
  end

  function automatic nor32_word_t pick_word();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      default: return $urandom();
    endcase
  endfunction

  initial begin
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.A        = '0;
    bus.B        = '0;

    // Test 1: reset for two edges
    cycle(1'b1, 1'b0, '0, '0);
    cycle(1'b1, 1'b0, '0, '0);
    check_out("reset", 1'b0, 32'h0000_0000);
`ifdef NOR32_ZERO_FLAG_EN
    check("reset.zero", 64'(bus.zero), 64'(1'b1));
`endif

    // Test 2: A all-ones forces zero
    cycle(1'b0, 1'b1, 32'hFFFF_FFFF, 32'h40A0_0400);
    check_out("t2", 1'b1, 32'h0000_0000);

    // Test 3: mixed pattern
    cycle(1'b0, 1'b1, 32'h2222_0225, 32'hC242_0423);
    check_out("t3", 1'b1, 32'h1D9D_F9D8);
`ifdef NOR32_ZERO_FLAG_EN
    check("t3.zero", 64'(bus.zero), 64'(1'b0));
`endif

    // Test 4: both zero gives all-ones, then held while idle
    cycle(1'b0, 1'b1, 32'h0000_0000, 32'h0000_0000);
    check_out("t4a", 1'b1, 32'hFFFF_FFFF);
    cycle(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check_out("t4b", 1'b0, 32'hFFFF_FFFF);

    // Idle cycle with undriven operands must not disturb R
    cycle(1'b0, 1'b0, 'x, 'x);
    check_out("idle_x", 1'b0, 32'hFFFF_FFFF);

    // Test 5: back-to-back pairs
    cycle(1'b0, 1'b1, 32'hFFFF_FFFF, 32'h40A0_0400);
    check_out("t5a", 1'b1, 32'h0000_0000);
    cycle(1'b0, 1'b1, 32'h2222_0225, 32'hC242_0423);
    check_out("t5b", 1'b1, 32'h1D9D_F9D8);

    // A = ~B boundary
    cycle(1'b0, 1'b1, 32'h1234_5678, 32'hEDCB_A987);
    check_out("a_not_b", 1'b1, 32'h0000_0000);

    // Test 6: reset wins over a valid pair
    cycle(1'b1, 1'b1, 32'h0000_0000, 32'h0000_0000);
    check_out("t6", 1'b0, 32'h0000_0000);
`ifdef NOR32_ZERO_FLAG_EN
    check("t6.zero", 64'(bus.zero), 64'(1'b1));
`endif

    // Random traffic, occasional reset
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 29) == 0, $urandom_range(0, 3) != 0, pick_word(), pick_word());
    end
    cycle(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    #1;
    check("sb.drained", 64'(exp_q.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
